// File: rtl/fp_align_add.sv
// Single-precision add/sub front end: unpack, order by magnitude,
// align exponents by iterative right shift, then add significands.
module fp_align_add #(
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign,
    output logic [23:0] fraction,
    output logic [7:0]  exponent,
    output logic        zero,
    output logic        exc
);

    typedef enum logic [2:0] {IDLE, ORDER, ALIGN, ADD, DONE} state_t;

    localparam logic [7:0] SPC = 8'(SHIFT_PER_CYCLE);

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        sub_q, sub_d;
    logic [23:0] sig_l_q, sig_l_d, sig_s_q, sig_s_d;
    logic [7:0]  exp_l_q, exp_l_d, d_q, d_d;
    logic        sgn_l_q, sgn_l_d, eff_sub_q, eff_sub_d;
    logic        out_valid_q, out_valid_d, sign_q, sign_d;
    logic [23:0] fraction_q, fraction_d;
    logic [7:0]  exponent_q, exponent_d;
    logic        zero_q, zero_d, exc_q, exc_d;

    logic [23:0] sig_a, sig_b;
    logic [31:0] key_a, key_b;
    logic        sgn_b, swap;
    logic [7:0]  shamt;
    logic [24:0] sum;

    always_comb begin
        sig_a = (a_q[30:23] != 8'd0) ? {1'b1, a_q[22:0]} : 24'd0;
        sig_b = (b_q[30:23] != 8'd0) ? {1'b1, b_q[22:0]} : 24'd0;
        key_a = {a_q[30:23], sig_a};
        key_b = {b_q[30:23], sig_b};
        sgn_b = b_q[31] ^ sub_q;
        swap  = key_b > key_a;
        shamt = (d_q < SPC) ? d_q : SPC;
        // L >= S by construction, so subtraction never wraps
        sum   = eff_sub_q ? ({1'b0, sig_l_q} - {1'b0, sig_s_q})
                          : ({1'b0, sig_l_q} + {1'b0, sig_s_q});

        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        sig_l_d     = sig_l_q;
        sig_s_d     = sig_s_q;
        exp_l_d     = exp_l_q;
        d_d         = d_q;
        sgn_l_d     = sgn_l_q;
        eff_sub_d   = eff_sub_q;
        out_valid_d = out_valid_q;
        sign_d      = sign_q;
        fraction_d  = fraction_q;
        exponent_d  = exponent_q;
        zero_d      = zero_q;
        exc_d       = exc_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = a;
                    b_d   = b;
                    sub_d = sub;
                    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        exc_d       = 1'b1;
                        exponent_d  = 8'hFF;
                        fraction_d  = 24'd0;
                        sign_d      = a[31];
                        zero_d      = 1'b0;
                    end else begin
                        state_d = ORDER;
                    end
                end
            end
            ORDER: begin
                sig_l_d   = swap ? sig_b : sig_a;
                sig_s_d   = swap ? sig_a : sig_b;
                exp_l_d   = swap ? b_q[30:23] : a_q[30:23];
                sgn_l_d   = swap ? sgn_b : a_q[31];
                eff_sub_d = a_q[31] ^ sgn_b;
                d_d       = swap ? (b_q[30:23] - a_q[30:23])
                                 : (a_q[30:23] - b_q[30:23]);
                state_d   = (d_d == 8'd0) ? ADD : ALIGN;
            end
            ALIGN: begin
                if (d_q >= 8'd26) begin
                    sig_s_d = 24'd0;
                    d_d     = 8'd0;
                    state_d = ADD;
                end else begin
                    sig_s_d = sig_s_q >> shamt;
                    d_d     = d_q - shamt;
                    if (d_q == shamt) state_d = ADD;
                end
            end
            ADD: begin
                state_d     = DONE;
                out_valid_d = 1'b1;
                exc_d       = 1'b0;
                if (sum == 25'd0) begin
                    zero_d     = 1'b1;
                    sign_d     = 1'b0;
                    exponent_d = 8'd0;
                    fraction_d = 24'd0;
                end else begin
                    zero_d     = 1'b0;
                    sign_d     = sgn_l_q;
                    exponent_d = exp_l_q;
                    fraction_d = sum[24:1];
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            sig_l_q     <= '0;
            sig_s_q     <= '0;
            exp_l_q     <= '0;
            d_q         <= '0;
            sgn_l_q     <= 1'b0;
            eff_sub_q   <= 1'b0;
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            fraction_q  <= '0;
            exponent_q  <= '0;
            zero_q      <= 1'b0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            sig_l_q     <= sig_l_d;
            sig_s_q     <= sig_s_d;
            exp_l_q     <= exp_l_d;
            d_q         <= d_d;
            sgn_l_q     <= sgn_l_d;
            eff_sub_q   <= eff_sub_d;
            out_valid_q <= out_valid_d;
            sign_q      <= sign_d;
            fraction_q  <= fraction_d;
            exponent_q  <= exponent_d;
            zero_q      <= zero_d;
            exc_q       <= exc_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sign      = sign_q;
    assign fraction  = fraction_q;
    assign exponent  = exponent_q;
    assign zero      = zero_q;
    assign exc       = exc_q;

endmodule
